ex_mem_stage: RTL
=================

Name: ex_mem_stage

Overview:
- EX/MEM pipeline register plus memory-access stage of the 64-bit LEGv8 pipeline; directly downstream of the execute stage.
- Latches execute results (ALU result, store data, branch target, zero flag) and their control bits.
- Drives a req/ack data-memory port and resolves branch-taken (PCSrc_M).
- Stalls the upstream pipeline while a load/store is outstanding, then hands results to the MEM/WB register.

Parameters:
N, 64, datapath width
TIMEOUT, 16, max REQ cycles waiting for dm_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
valid_E  in  1  instruction in EX is valid
memRead_E  in  1  load
memWrite_E  in  1  store
branch_E  in  1  conditional branch (CBZ)
regWrite_E  in  1  writes register file
writeReg_E  in  5  destination register
aluResult_E  in  N  ALU result / memory address
writeData_E  in  N  store data
PCBranch_E  in  N  branch target
zero_E  in  1  ALU zero flag
flush_E  in  1  squash instruction entering M
dm_addr  out  N  memory address
dm_wdata  out  N  store data
dm_req  out  1  memory request
dm_we  out  1  1=write, 0=read
dm_ack  in  1  memory completes request this cycle
dm_rdata  in  N  load data, valid with dm_ack
PCSrc_M  out  1  branch taken
PCBranch_M  out  N  branch target to fetch
stall_M  out  1  hold EX and earlier stages
mem_err  out  1  sticky timeout flag
valid_W  out  1  MEM/WB valid
regWrite_W  out  1  register write enable to WB
writeReg_W  out  5  destination to WB
aluResult_W  out  N  ALU result to WB
readData_W  out  N  load data to WB
memToReg_W  out  1  select readData_W in WB

Behaviour:
- Reset (reset=0, async): all M and W registers 0, FSM=IDLE, timeout counter 0, mem_err=0. dm_req, stall_M and PCSrc_M drop immediately, including mid-transaction; the aborted access is not retried.
- EX/MEM register:
  - When stall_M=0: loads all *_E fields at the clock edge; valid_M <= valid_E & ~flush_E.
  - When stall_M=1: holds all fields; flush_E is ignored.
- memOp_M = valid_M & (memRead_M | memWrite_M).
- FSM states:
  - IDLE: if memOp_M, go to REQ and clear counter.
  - REQ: dm_req=1, dm_we=memWrite_M, dm_addr=aluResult_M, dm_wdata=writeData_M. On dm_ack, go to IDLE. On counter==TIMEOUT-1 without ack, go to IDLE and set mem_err (abort). Otherwise increment the counter.
- dm_req is 0 outside REQ; dm_addr and dm_wdata are don't-care outside REQ.
- stall_M = memOp_M & ~(state==REQ & (dm_ack | timeout)). It is combinational, so stall drops in the ack cycle.
- Minimum M occupancy: 1 cycle for a non-memory instruction, 2 cycles for a load/store (IDLE cycle, then a REQ cycle with immediate ack).
- PCSrc_M = valid_M & branch_M & zero_M (combinational). PCBranch_M is the register output. Squashing younger instructions is done by the controller via flush_E.
- MEM/WB register, each edge:
  - When stall_M=1: valid_W<=0 and regWrite_W<=0 (bubble); other fields are don't-care.
  - When stall_M=0:
    - valid_W<=valid_M
    - regWrite_W<=valid_M & regWrite_M
    - memToReg_W<=memRead_M
    - writeReg_W, aluResult_W pass through
    - readData_W<=dm_rdata if memRead_M & ack, 0 if aborted, otherwise hold
- dm_ack outside REQ is ignored.
- mem_err clears only on reset.
- A store never sets regWrite_W, even if regWrite_E=1 is presented.

Test Plan:
- Reset asserted mid-REQ (aluResult=0x40, load) -> dm_req, stall_M, valid_W drop to 0 asynchronously; FSM IDLE after release; no retry.
- ALU op (regWrite_E=1, writeReg=3, aluResult=0x1234), no memory op -> one cycle later valid_W=1, writeReg_W=3, aluResult_W=0x1234, stall_M never 1.
- Load addr 0x80, dm_ack 3 cycles after dm_req, rdata=0xDEADBEEF -> stall_M=1 for 4 cycles, dm_we=0, dm_addr=0x80; next cycle readData_W=0xDEADBEEF, memToReg_W=1; bubbles (valid_W=0) during stall.
- Store addr 0x10, data 0x55, immediate ack -> dm_req=1 and dm_we=1 for one cycle, dm_wdata=0x55, stall 1 cycle, regWrite_W=0.
- CBZ with zero_E=1, PCBranch_E=0x200 -> PCSrc_M=1, PCBranch_M=0x200 for one cycle. Same with zero_E=0 -> PCSrc_M=0. Same with flush_E=1 -> PCSrc_M=0.
- Load with dm_ack never asserted, TIMEOUT=16 -> dm_req high exactly 16 cycles, mem_err=1 sticky, readData_W=0, pipeline resumes.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// Data-memory request/acknowledge port of the EX/MEM stage.
// The stage is the master: it drives address, store data, request and
// direction; the memory answers with ack and load data in the same cycle.
interface ex_mem_stage_if #(
    parameter int N = 64
);
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic         dm_req;
    logic         dm_we;
    logic         dm_ack;
    logic [N-1:0] dm_rdata;

    modport master (
        output dm_addr,
        output dm_wdata,
        output dm_req,
        output dm_we,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_addr,
        input  dm_wdata,
        input  dm_req,
        input  dm_we,
        output dm_ack,
        output dm_rdata
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register and memory-access stage of the 64-bit LEGv8 pipe.
// Latches execute results, runs a two-state req/ack memory FSM with an
// abort timeout, resolves CBZ branches and feeds the MEM/WB register.
// The whole upstream pipe is held (stall_M) while a load/store is in flight.
module ex_mem_stage #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         valid_E,
    input  logic         memRead_E,
    input  logic         memWrite_E,
    input  logic         branch_E,
    input  logic         regWrite_E,
    input  logic [4:0]   writeReg_E,
    input  logic [N-1:0] aluResult_E,
    input  logic [N-1:0] writeData_E,
    input  logic [N-1:0] PCBranch_E,
    input  logic         zero_E,
    input  logic         flush_E,

    ex_mem_stage_if.master dm,

    output logic         PCSrc_M,
    output logic [N-1:0] PCBranch_M,
    output logic         stall_M,
    output logic         mem_err,

    output logic         valid_W,
    output logic         regWrite_W,
    output logic [4:0]   writeReg_W,
    output logic [N-1:0] aluResult_W,
    output logic [N-1:0] readData_W,
    output logic         memToReg_W
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // EX/MEM register
    logic             r_valid_M;
    logic             r_memRead_M;
    logic             r_memWrite_M;
    logic             r_branch_M;
    logic             r_regWrite_M;
    logic [4:0]       r_writeReg_M;
    logic [N-1:0]     r_aluResult_M;
    logic [N-1:0]     r_writeData_M;
    logic [N-1:0]     r_PCBranch_M;
    logic             r_zero_M;

    // MEM/WB register
    logic             r_valid_W;
    logic             r_regWrite_W;
    logic [4:0]       r_writeReg_W;
    logic [N-1:0]     r_aluResult_W;
    logic [N-1:0]     r_readData_W;
    logic             r_memToReg_W;

    logic             r_mem_err;

    logic             w_memOp;
    logic             w_in_req;
    logic             w_ack;
    logic             w_timeout;
    logic             w_stall;

    assign w_memOp   = r_valid_M & (r_memRead_M | r_memWrite_M);
    assign w_in_req  = (r_state == S_REQ);
    // ack is only meaningful while a request is on the bus
    assign w_ack     = w_in_req & dm.dm_ack;
    // abort on the last allowed REQ cycle unless the memory answers in it
    assign w_timeout = w_in_req & ~dm.dm_ack & (r_cnt == CNT_LAST);
    // stall releases combinationally in the completing cycle
    assign w_stall   = w_memOp & ~(w_ack | w_timeout);

    // State register and REQ-cycle counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state: issue after one IDLE cycle, leave REQ on ack or timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_memOp) begin
                    w_state_nxt = S_REQ;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                if (w_ack || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM outputs: memory port driven only in REQ
    always_comb begin
        dm.dm_req   = 1'b0;
        dm.dm_we    = 1'b0;
        dm.dm_addr  = r_aluResult_M;
        dm.dm_wdata = r_writeData_M;
        if (r_state == S_REQ) begin
            dm.dm_req = 1'b1;
            dm.dm_we  = r_memWrite_M;
        end
    end

    // EX/MEM register: load when not stalled, flush only takes effect on load
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_M     <= 1'b0;
            r_memRead_M   <= 1'b0;
            r_memWrite_M  <= 1'b0;
            r_branch_M    <= 1'b0;
            r_regWrite_M  <= 1'b0;
            r_writeReg_M  <= '0;
            r_aluResult_M <= '0;
            r_writeData_M <= '0;
            r_PCBranch_M  <= '0;
            r_zero_M      <= 1'b0;
        end else if (!w_stall) begin
            r_valid_M     <= valid_E & ~flush_E;
            r_memRead_M   <= memRead_E;
            r_memWrite_M  <= memWrite_E;
            r_branch_M    <= branch_E;
            r_regWrite_M  <= regWrite_E;
            r_writeReg_M  <= writeReg_E;
            r_aluResult_M <= aluResult_E;
            r_writeData_M <= writeData_E;
            r_PCBranch_M  <= PCBranch_E;
            r_zero_M      <= zero_E;
        end
    end

    // MEM/WB register: bubble while stalled, pass results once M completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid_W     <= 1'b0;
            r_regWrite_W  <= 1'b0;
            r_writeReg_W  <= '0;
            r_aluResult_W <= '0;
            r_readData_W  <= '0;
            r_memToReg_W  <= 1'b0;
        end else if (w_stall) begin
            r_valid_W    <= 1'b0;
            r_regWrite_W <= 1'b0;
        end else begin
            r_valid_W     <= r_valid_M;
            // stores never write the register file
            r_regWrite_W  <= r_valid_M & r_regWrite_M & ~r_memWrite_M;
            r_writeReg_W  <= r_writeReg_M;
            r_aluResult_W <= r_aluResult_M;
            r_memToReg_W  <= r_memRead_M;
            if (r_memRead_M && w_ack) begin
                r_readData_W <= dm.dm_rdata;
            end else if (w_timeout) begin
                r_readData_W <= '0;
            end
        end
    end

    // Sticky abort flag, cleared only by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_err <= 1'b0;
        end else if (w_timeout) begin
            r_mem_err <= 1'b1;
        end
    end

    assign stall_M     = w_stall;
    assign PCSrc_M     = r_valid_M & r_branch_M & r_zero_M;
    assign PCBranch_M  = r_PCBranch_M;
    assign mem_err     = r_mem_err;
    assign valid_W     = r_valid_W;
    assign regWrite_W  = r_regWrite_W;
    assign writeReg_W  = r_writeReg_W;
    assign aluResult_W = r_aluResult_W;
    assign readData_W  = r_readData_W;
    assign memToReg_W  = r_memToReg_W;

endmodule
